alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the operand/result width matching the shared ALU.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have ports req0_valid and req1_valid, input, 1, requester N has an operation pending.
REQ-005 The block SHALL have ports req0_oper and req1_oper, input, 3, ALU opcode (000 add, 001 inc, 010 sub, 011 dec, 100 shl, 101 shr, 110 nand, 111 A>B).
REQ-006 The block SHALL have ports req0_a, req0_b, req1_a and req1_b, input, WIDTH, operands of requester N.
REQ-007 The block SHALL have ports req0_ready and req1_ready, output, 1, request N accepted this cycle.
REQ-008 The block SHALL have port rsp_valid, output, 1, response available.
REQ-009 The block SHALL have port rsp_ready, input, 1, response consumer accepts.
REQ-010 The block SHALL have port rsp_id, output, 1, index of the requester owning the response.
REQ-011 The block SHALL have ports rsp_data, output, WIDTH, and rsp_cy, output, 1, the registered ALU result and carry.
REQ-012 The block SHALL have ports alu_oper, output, 3, alu_a, output, WIDTH, and alu_b, output, WIDTH, driven to the external combinational ALU.
REQ-013 The block SHALL have ports alu_out, input, WIDTH, and alu_cy, input, 1, returned from the ALU.
REQ-014 The block SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, EXEC and RESP, with one transaction in flight at most.
REQ-016 In IDLE with any reqN_valid high, the block SHALL grant one requester, pulse its reqN_ready for exactly that cycle, latch its oper/a/b and id, and go to EXEC.
REQ-017 Arbitration SHALL be round-robin: a 1-bit priority pointer (reset 0) names the preferred requester; the non-preferred one is granted only when the preferred one is not valid.
REQ-018 The pointer SHALL update to the non-granted index at each grant, so that with both valid continuously, grants alternate 0,1,0,1.
REQ-019 reqN_ready SHALL be combinational from state, valid and pointer, and SHALL never be high in EXEC or RESP or for both requesters at once.
REQ-020 alu_oper/alu_a/alu_b SHALL be driven only from the latched registers, and SHALL be stable from EXEC until return to IDLE.
REQ-021 In EXEC the block SHALL capture alu_out/alu_cy into rsp_data/rsp_cy at the clock edge and go to RESP; accept-to-rsp_valid latency is 2 cycles.
REQ-022 In RESP, rsp_valid SHALL be high with rsp_id/rsp_data/rsp_cy held stable until the cycle rsp_ready is high, then go to IDLE.
REQ-023 rsp_ready high outside RESP SHALL be ignored.
REQ-024 A new grant SHALL NOT occur in the same cycle as response completion; the earliest next reqN_ready is the cycle after RESP exits.
REQ-025 Requests dropped (valid deasserted) before being granted SHALL be lost without side effects; the block SHALL not latch operands of an ungranted requester.
REQ-026 The block SHALL neither interpret opcodes nor modify carry; results are the ALU's, passed through unchanged.

Reset
REQ-027 When rst is high at a clock edge, the block SHALL enter IDLE, set the pointer to 0, and clear the latched oper/a/b, rsp_data, rsp_cy and rsp_id to 0, aborting any in-flight transaction with no response.
REQ-028 During and after reset, until the next grant: rsp_valid=0, busy=0, alu_oper=000, alu_a=0 and alu_b=0; reqN_ready follows REQ-016/REQ-019.

Verification
REQ-029 Requester 0 only, oper=000, a=FF, b=09, rsp_ready=1 -> req0_ready pulses 1 cycle, rsp_valid 2 cycles later with rsp_id=0, rsp_data=08, rsp_cy=1.
REQ-030 Both valid after reset, requester 0 oper=010, a=25, b=03 and requester 1 oper=110, a=AA, b=5A -> first response id0 data=22, second id1 data=F5; repeated stimulus alternates ids.
REQ-031 Requester 1 oper=111, a=13, b=12, rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_id=1 and rsp_data=01 stay stable, no reqN_ready pulses, busy=1; completes on the first rsp_ready.
REQ-032 Assert rst during EXEC -> next cycle IDLE, rsp_valid=0, busy=0, alu_a=0 and pointer=0, so a simultaneous both-valid request grants requester 0.
REQ-033 Requester 0 oper=100, a=AA -> rsp_data=54 and rsp_cy=1 per ALU model; alu_* remain stable from EXEC through RESP.
REQ-034 Pulse rsp_ready in IDLE with no requests -> no state change and rsp_valid stays 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU
// between two requesters, one transaction in flight at a time.
module alu_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [2:0]       req0_oper,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [2:0]       req1_oper,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_cy,
  output logic [2:0]       alu_oper,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cy,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             ptr;
  logic             id_q;
  logic [2:0]       oper_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] data_q;
  logic             cy_q;

  logic             both;
  logic             gnt0;
  logic             gnt1;
  logic             grant;

  assign both = req0_valid & req1_valid;

  // Grants only exist in IDLE; the pointer breaks ties.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE) begin
      unique case (1'b1)
        both: begin
          gnt0 = ~ptr;
          gnt1 = ptr;
        end
        req0_valid & ~req1_valid: gnt0 = 1'b1;
        req1_valid & ~req0_valid: gnt1 = 1'b1;
        default: ;
      endcase
    end
  end

  assign grant = gnt0 | gnt1;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (grant) state_nxt = EXEC;
      EXEC: state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= 1'b0;
      id_q   <= 1'b0;
      oper_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      data_q <= '0;
      cy_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        ptr    <= ~gnt1;
        id_q   <= gnt1;
        oper_q <= gnt1 ? req1_oper : req0_oper;
        a_q    <= gnt1 ? req1_a : req0_a;
        b_q    <= gnt1 ? req1_b : req0_b;
      end
      if (state == EXEC) begin
        data_q <= alu_out;
        cy_q   <= alu_cy;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp_valid  = (state == RESP);
  assign rsp_id     = id_q;
  assign rsp_data   = data_q;
  assign rsp_cy     = cy_q;
  assign alu_oper   = oper_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios then random traffic,
// checked cycle by cycle against a transaction-level model.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid;
  logic [2:0] req0_oper;
  logic [7:0] req0_a;
  logic [7:0] req0_b;
  logic       req0_ready;
  logic       req1_valid;
  logic [2:0] req1_oper;
  logic [7:0] req1_a;
  logic [7:0] req1_b;
  logic       req1_ready;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [7:0] rsp_data;
  logic       rsp_cy;
  logic [2:0] alu_oper;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_out;
  logic       alu_cy;
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: phase 0 waiting, 1 computing, 2 offering result
  int         m_phase;
  logic       m_ptr;
  logic       m_id;
  logic [2:0] m_oper;
  logic [7:0] m_a;
  logic [7:0] m_b;
  logic [7:0] m_data;
  logic       m_cy;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_oper  (req0_oper),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_oper  (req1_oper),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_cy     (rsp_cy),
    .alu_oper   (alu_oper),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_out    (alu_out),
    .alu_cy     (alu_cy),
    .busy       (busy)
  );

  function automatic logic [8:0] alu_f(
    input logic [2:0] op,
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [8:0] r;
    case (op)
      3'd0: r = {1'b0, a} + {1'b0, b};
      3'd1: r = {1'b0, a} + 9'd1;
      3'd2: r = {1'b0, a} - {1'b0, b};
      3'd3: r = {1'b0, a} - 9'd1;
      3'd4: r = {a, 1'b0};
      3'd5: r = {a[0], 1'b0, a[7:1]};
      3'd6: r = {1'b0, ~(a & b)};
      default: r = (a > b) ? 9'd1 : 9'd0;
    endcase
    return r;
  endfunction

  always_comb {alu_cy, alu_out} = alu_f(alu_oper, alu_a, alu_b);

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(
    input logic       r,
    input logic       v0,
    input logic [2:0] o0,
    input logic [7:0] a0,
    input logic [7:0] b0,
    input logic       v1,
    input logic [2:0] o1,
    input logic [7:0] a1,
    input logic [7:0] b1,
    input logic       rr
  );
    logic win;
    logic e0;
    logic e1;
    logic [8:0] res;
    @(negedge clk);
    rst        = r;
    req0_valid = v0;
    req0_oper  = o0;
    req0_a     = a0;
    req0_b     = b0;
    req1_valid = v1;
    req1_oper  = o1;
    req1_a     = a1;
    req1_b     = b1;
    rsp_ready  = rr;
    #1;
    win = (v0 && v1) ? m_ptr : v1;
    e0  = (m_phase == 0) && (v0 || v1) && !win;
    e1  = (m_phase == 0) && (v0 || v1) && win;
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    chk("rsp_valid", rsp_valid, m_phase == 2);
    chk("busy", busy, m_phase != 0);
    chk("alu_oper", alu_oper, m_oper);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("rsp_id", rsp_id, m_id);
    chk("rsp_data", rsp_data, m_data);
    chk("rsp_cy", rsp_cy, m_cy);
    if (r) begin
      m_phase = 0;
      m_ptr   = 1'b0;
      m_id    = 1'b0;
      m_oper  = '0;
      m_a     = '0;
      m_b     = '0;
      m_data  = '0;
      m_cy    = 1'b0;
    end else if (m_phase == 0) begin
      if (v0 || v1) begin
        m_id    = win;
        m_ptr   = ~win;
        m_oper  = win ? o1 : o0;
        m_a     = win ? a1 : a0;
        m_b     = win ? b1 : b0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      res     = alu_f(m_oper, m_a, m_b);
      m_data  = res[7:0];
      m_cy    = res[8];
      m_phase = 2;
    end else if (rr) begin
      m_phase = 0;
    end
  endtask

  task automatic idle(input logic rr);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 8'h00,
        1'b0, 3'd0, 8'h00, 8'h00, rr);
  endtask

  task automatic both(input logic rr);
    cyc(1'b0, 1'b1, 3'd2, 8'h25, 8'h03,
        1'b1, 3'd6, 8'hAA, 8'h5A, rr);
  endtask

  initial begin
    rst        = 1'b1;
    req0_valid = 1'b0;
    req0_oper  = '0;
    req0_a     = '0;
    req0_b     = '0;
    req1_valid = 1'b0;
    req1_oper  = '0;
    req1_a     = '0;
    req1_b     = '0;
    rsp_ready  = 1'b0;
    m_phase    = 0;
    m_ptr      = 1'b0;
    m_id       = 1'b0;
    m_oper     = '0;
    m_a        = '0;
    m_b        = '0;
    m_data     = '0;
    m_cy       = 1'b0;
    repeat (2) @(posedge clk);

    idle(1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);

    cyc(1'b0, 1'b1, 3'd0, 8'hFF, 8'h09,
        1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
    chk("add_ready", req0_ready, 1'b1);
    idle(1'b1);
    chk("add_lat", rsp_valid, 1'b0);
    idle(1'b1);
    chk("add_valid", rsp_valid, 1'b1);
    chk("add_id", rsp_id, 1'b0);
    chk("add_data", rsp_data, 8'h08);
    chk("add_cy", rsp_cy, 1'b1);

    cyc(1'b1, 1'b0, 3'd0, 8'h00, 8'h00,
        1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    both(1'b1);
    chk("rr_g0", req0_ready, 1'b1);
    both(1'b1);
    both(1'b1);
    chk("rr_id0", rsp_id, 1'b0);
    chk("rr_d0", rsp_data, 8'h22);
    both(1'b1);
    chk("rr_g1", req1_ready, 1'b1);
    both(1'b1);
    both(1'b1);
    chk("rr_id1", rsp_id, 1'b1);
    chk("rr_d1", rsp_data, 8'hF5);

    cyc(1'b0, 1'b0, 3'd0, 8'h00, 8'h00,
        1'b1, 3'd7, 8'h13, 8'h12, 1'b0);
    chk("gt_ready", req1_ready, 1'b1);
    both(1'b0);
    for (int i = 0; i < 5; i++) begin
      both(1'b0);
      chk("hold_valid", rsp_valid, 1'b1);
      chk("hold_id", rsp_id, 1'b1);
      chk("hold_data", rsp_data, 8'h01);
      chk("hold_busy", busy, 1'b1);
      chk("hold_r0", req0_ready, 1'b0);
      chk("hold_r1", req1_ready, 1'b0);
    end
    both(1'b1);
    chk("hold_done_r0", req0_ready, 1'b0);

    both(1'b1);
    chk("pre_rst_g0", req0_ready, 1'b1);
    cyc(1'b1, 1'b0, 3'd0, 8'h00, 8'h00,
        1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
    chk("abort_busy_in", busy, 1'b1);
    both(1'b1);
    chk("abort_valid", rsp_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_alu_a", alu_a, 8'h00);
    chk("abort_g0", req0_ready, 1'b1);
    idle(1'b1);
    idle(1'b1);

    cyc(1'b0, 1'b1, 3'd4, 8'hAA, 8'h00,
        1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    idle(1'b0);
    chk("shl_alu_op", alu_oper, 3'd4);
    idle(1'b1);
    chk("shl_data", rsp_data, 8'h54);
    chk("shl_cy", rsp_cy, 1'b1);
    chk("shl_alu_a", alu_a, 8'hAA);

    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      chk("idle_rr_valid", rsp_valid, 1'b0);
      chk("idle_rr_busy", busy, 1'b0);
    end

    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 49) == 0,
          1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom),
          1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom),
          $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
